top: RTL and testbench



---
 rtl/top.sv | 61 ++++++
 tb/tb_top.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// Byte to dual hex seven-segment driver.
// Dig1 shows Value[7:4], Dig2 shows Value[3:0]; outputs are registered.
module top #(
    parameter int COMMON_ANODE = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Value,
    output logic [7:0] SevenSegDig1,
    output logic [7:0] SevenSegDig2
);

    // XOR mask: all ones flips the glyphs for common-anode parts
    localparam logic [7:0] POL_MASK = (COMMON_ANODE != 0) ? 8'hFF : 8'h00;

    logic [7:0] dig1_d, dig1_q;
    logic [7:0] dig2_d, dig2_q;

    // Segment order is {dp,g,f,e,d,c,b,a}; dp stays off
    function automatic logic [7:0] decode(input logic [3:0] nib);
        logic [7:0] seg;
        unique case (nib)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            4'hF: seg = 8'h71;
        endcase
        return seg;
    endfunction

    always_comb begin
        dig1_d = decode(Value[7:4]) ^ POL_MASK;
        dig2_d = decode(Value[3:0]) ^ POL_MASK;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dig1_q <= POL_MASK;
            dig2_q <= POL_MASK;
        end else begin
            dig1_q <= dig1_d;
            dig2_q <= dig2_d;
        end
    end

    assign SevenSegDig1 = dig1_q;
    assign SevenSegDig2 = dig2_q;

endmodule

// File: tb/tb_top.sv
// Directed bench for the dual hex seven-segment driver.
// Checks both polarities side by side on a shared stimulus.
module tb_top;

    logic       Clk;
    logic       Reset;
    logic [7:0] Value;
    logic [7:0] ca0_d1, ca0_d2;
    logic [7:0] ca1_d1, ca1_d2;

    int checks;
    int failures;

    localparam logic [7:0] GLYPH [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    localparam logic [31:0] BLANK = {8'h00, 8'h00, 8'hFF, 8'hFF};

    top #(.COMMON_ANODE(0)) u_cc (
        .Clk          (Clk),
        .Reset        (Reset),
        .Value        (Value),
        .SevenSegDig1 (ca0_d1),
        .SevenSegDig2 (ca0_d2)
    );

    top #(.COMMON_ANODE(1)) u_ca (
        .Clk          (Clk),
        .Reset        (Reset),
        .Value        (Value),
        .SevenSegDig1 (ca1_d1),
        .SevenSegDig2 (ca1_d2)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] obs();
        return {ca0_d1, ca0_d2, ca1_d1, ca1_d2};
    endfunction

    function automatic logic [31:0] expv(input logic [7:0] v);
        logic [7:0] hi, lo;
        hi = GLYPH[v[7:4]];
        lo = GLYPH[v[3:0]];
        return {hi, lo, ~hi, ~lo};
    endfunction

    task automatic test_reset();
        logic [31:0] o;
        Reset = 1'b0;
        Value = 8'h55;
        repeat (2) @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        o = obs();
        checks++;
        if (o !== BLANK) begin
            failures++;
            $display("FAIL reset_async got=%h exp=%h", o, BLANK);
        end
        Value = 8'hA7;
        repeat (2) @(posedge Clk);
        #1;
        o = obs();
        checks++;
        if (o !== BLANK) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", o, BLANK);
        end
    endtask

    task automatic test_basic();
        logic [31:0] o;
        @(negedge Clk);
        Value = 8'h8C;
        Reset = 1'b0;
        #1;
        o = obs();
        checks++;
        if (o !== BLANK) begin
            failures++;
            $display("FAIL release_no_edge got=%h exp=%h", o, BLANK);
        end
        @(posedge Clk);
        #1;
        o = obs();
        checks++;
        if (o !== {8'h7F, 8'h39, 8'h80, 8'hC6}) begin
            failures++;
            $display("FAIL basic_8C got=%h exp=%h",
                     o, {8'h7F, 8'h39, 8'h80, 8'hC6});
        end
    endtask

    task automatic test_sweep();
        logic [31:0] o;
        for (int i = 0; i < 256; i++) begin
            @(negedge Clk);
            Value = 8'(i);
            @(posedge Clk);
            #1;
            o = obs();
            checks++;
            if (o !== expv(8'(i))) begin
                failures++;
                $display("FAIL sweep_%h got=%h exp=%h",
                         i[7:0], o, expv(8'(i)));
            end
        end
        @(negedge Clk);
        Value = 8'h3F;
        @(posedge Clk);
        #1;
        o = obs();
        checks++;
        if (o !== {8'h4F, 8'h71, 8'hB0, 8'h8E}) begin
            failures++;
            $display("FAIL sweep_3F got=%h exp=%h",
                     o, {8'h4F, 8'h71, 8'hB0, 8'h8E});
        end
    endtask

    task automatic test_mid_cycle();
        logic [31:0] o;
        @(negedge Clk);
        Value = 8'h12;
        @(posedge Clk);
        #1;
        o = obs();
        checks++;
        if (o !== {8'h06, 8'h5B, 8'hF9, 8'hA4}) begin
            failures++;
            $display("FAIL mid_12 got=%h exp=%h",
                     o, {8'h06, 8'h5B, 8'hF9, 8'hA4});
        end
        #2;
        Value = 8'hAB;
        #1;
        o = obs();
        checks++;
        if (o !== {8'h06, 8'h5B, 8'hF9, 8'hA4}) begin
            failures++;
            $display("FAIL mid_hold got=%h exp=%h",
                     o, {8'h06, 8'h5B, 8'hF9, 8'hA4});
        end
        @(posedge Clk);
        #1;
        o = obs();
        checks++;
        if (o !== {8'h77, 8'h7C, 8'h88, 8'h83}) begin
            failures++;
            $display("FAIL mid_AB got=%h exp=%h",
                     o, {8'h77, 8'h7C, 8'h88, 8'h83});
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] o;
        @(negedge Clk);
        Value = 8'h8C;
        @(posedge Clk);
        #1;
        o = obs();
        checks++;
        if (o !== {8'h7F, 8'h39, 8'h80, 8'hC6}) begin
            failures++;
            $display("FAIL rmid_pre got=%h exp=%h",
                     o, {8'h7F, 8'h39, 8'h80, 8'hC6});
        end
        #2;
        Reset = 1'b1;
        #1;
        o = obs();
        checks++;
        if (o !== BLANK) begin
            failures++;
            $display("FAIL rmid_async got=%h exp=%h", o, BLANK);
        end
        Value = 8'h3F;
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        o = obs();
        checks++;
        if (o !== BLANK) begin
            failures++;
            $display("FAIL rmid_release got=%h exp=%h", o, BLANK);
        end
        @(posedge Clk);
        #1;
        o = obs();
        checks++;
        if (o !== {8'h4F, 8'h71, 8'hB0, 8'h8E}) begin
            failures++;
            $display("FAIL rmid_reload got=%h exp=%h",
                     o, {8'h4F, 8'h71, 8'hB0, 8'h8E});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] o;
        logic [7:0] v;
        v = 8'hE0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            Value = v;
            @(posedge Clk);
            #1;
            o = obs();
            checks++;
            if (o !== expv(v)) begin
                failures++;
                $display("FAIL b2b_%h got=%h exp=%h", v, o, expv(v));
            end
            v = v + 8'h13;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b0;
        Value    = 8'h00;
        test_reset();
        test_basic();
        test_sweep();
        test_mid_cycle();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
